// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read channel among NUM_REQ requesters.
// One burst in flight; beats are counted, steered to the owner, and timed out.
module dram_read_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int GW = $clog2(NUM_REQ),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                           clk_pixel,
  input  logic                           dram_arbiter_reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]           req_len,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [NUM_REQ-1:0]             resp_last,
  output logic [DRAM_DATA_WIDTH-1:0]     resp_data,
  output logic [GW-1:0]                  grant_id,
  output logic                           arb_timeout,
  output logic                           stray_beat,
  output logic [DRAM_ADDR_WIDTH-1:0]     dram_read_addr,
  output logic [7:0]                     dram_read_len,
  output logic                           dram_read_en,
  input  logic [DRAM_DATA_WIDTH-1:0]     dram_read_data,
  input  logic                           dram_read_data_valid,
  input  logic                           dram_read_busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic          found;
  logic          accept;
  logic          is_last;
  logic [8:0]    beat_cnt;
  logic [TW-1:0] tmo;

  // Search starts just past the last owner so it becomes lowest priority.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && !dram_read_busy && found;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[pick] = 1'b1;
  end

  assign is_last = (beat_cnt == {1'b0, dram_read_len});

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = dram_read_data_valid
                   && (state == WAIT_DATA)
                   && (grant_id == GW'(i));
  end

  assign resp_last    = resp_valid & {NUM_REQ{is_last}};
  assign resp_data    = dram_read_data;
  assign dram_read_en = (state == ISSUE);

  always_ff @(posedge clk_pixel) begin
    if (dram_arbiter_reset) begin
      state          <= IDLE;
      dram_read_addr <= '0;
      dram_read_len  <= '0;
      grant_id       <= '0;
      last_grant     <= GW'(NUM_REQ - 1);
      beat_cnt       <= '0;
      tmo            <= '0;
      arb_timeout    <= 1'b0;
      stray_beat     <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      stray_beat  <= dram_read_data_valid && (state != WAIT_DATA);
      unique case (state)
        IDLE: begin
          if (accept) begin
            dram_read_addr <= req_addr[int'(pick)*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
            dram_read_len  <= req_len[int'(pick)*8 +: 8];
            grant_id       <= pick;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          beat_cnt <= '0;
          tmo      <= '0;
          state    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (dram_read_data_valid) begin
            tmo      <= '0;
            beat_cnt <= beat_cnt + 9'd1;
            if (is_last) begin
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            arb_timeout <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed, table-driven bench for dram_read_arbiter.
// Each table row is one clock: inputs driven at negedge, outputs checked 1ns later.
module tb_dram_read_arbiter;

  localparam int NR = 2;
  localparam int AW = 39;
  localparam int DW = 64;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*8-1:0] req_len;
  logic [NR-1:0]   resp_valid;
  logic [NR-1:0]   resp_last;
  logic [DW-1:0]   resp_data;
  logic            grant_id;
  logic            arb_timeout;
  logic            stray_beat;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_len;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            rd_dv;
  logic            rd_busy;

  dram_read_arbiter #(
    .NUM_REQ(NR), .DRAM_ADDR_WIDTH(AW),
    .DRAM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_pixel(clk),
    .dram_arbiter_reset(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_len(req_len),
    .resp_valid(resp_valid),
    .resp_last(resp_last),
    .resp_data(resp_data),
    .grant_id(grant_id),
    .arb_timeout(arb_timeout),
    .stray_beat(stray_beat),
    .dram_read_addr(rd_addr),
    .dram_read_len(rd_len),
    .dram_read_en(rd_en),
    .dram_read_data(rd_data),
    .dram_read_data_valid(rd_dv),
    .dram_read_busy(rd_busy)
  );

  always #5 clk = ~clk;

  localparam logic [AW-1:0] A0 = 39'h1000;
  localparam logic [AW-1:0] A1 = 39'h2000;

  typedef struct {
    bit         rst;
    logic [1:0] rv;
    bit         busy;
    bit         dv;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [1:0] rdy;
    bit         en;
    logic [1:0] rvl;
    logic [1:0] rl;
    bit         gid;
    bit         stray;
    bit         tmo;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    bit rst_i, logic [1:0] rv, bit busy, bit dv,
    logic [7:0] l0, logic [7:0] l1,
    logic [1:0] rdy, bit en, logic [1:0] rvl, logic [1:0] rl,
    bit gid, bit stray, bit tmo);
    vec_t v;
    v.rst = rst_i; v.rv = rv; v.busy = busy; v.dv = dv;
    v.l0 = l0; v.l1 = l1; v.rdy = rdy; v.en = en;
    v.rvl = rvl; v.rl = rl; v.gid = gid;
    v.stray = stray; v.tmo = tmo;
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input string got,
                       input string want);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s required %s", name, got, want);
    end
  endtask

  initial begin
    logic [1:0] oh;
    bit g;
    bit prev;
    int cnt;
    int lastpos;
    bit data_ok;

    // Test 1: single req0, len 0
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 3, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b01, 2'b01, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    // Test 2: both held valid, len 3, beats 2 cycles after en
    tbl.push_back(mk(1, 2'b00, 0, 0, 3, 3, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    for (int b = 0; b < 4; b++) begin
      g    = bit'(b % 2);
      prev = (b == 0) ? 1'b0 : bit'((b - 1) % 2);
      oh   = g ? 2'b10 : 2'b01;
      tbl.push_back(mk(0, 2'b11, 0, 0, 3, 3, oh, 0, 2'b00, 2'b00, prev, 0, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 3, 3, 2'b00, 1, 2'b00, 2'b00, g, 0, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 3, 3, 2'b00, 0, 2'b00, 2'b00, g, 0, 0));
      for (int k = 0; k < 4; k++)
        tbl.push_back(mk(0, 2'b11, 0, 1, 3, 3, 2'b00, 0, oh,
                         (k == 3) ? oh : 2'b00, g, 0, 0));
    end
    tbl.push_back(mk(0, 2'b00, 0, 0, 3, 3, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0));
    // Test 3: busy blocks req1, then released
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 2'b10, 1, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 3, 2'b10, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 0, 0, 3, 2'b00, 1, 2'b00, 2'b00, 1, 0, 0));
    // Test 5: no beats for TO cycles, abort, req0 next, late beat is stray
    for (int k = 0; k < TO; k++)
      tbl.push_back(mk(0, 2'b01, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 1, 0, 3, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 1, 2'b00, 2'b00, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b01, 2'b01, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    // Test 6: reset in the middle of a req1 burst
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 3, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 1, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b10, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b10, 2'b00, 1, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0));

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = {A1, A0};
    req_len   = '0;
    rd_data   = '0;
    rd_dv     = 1'b0;
    rd_busy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state",
          rd_en === 1'b0 && rd_addr === '0 && rd_len === 8'd0 &&
          grant_id === 1'b0 && arb_timeout === 1'b0 &&
          stray_beat === 1'b0 && req_ready === 2'b00,
          $sformatf("en=%b addr=%h len=%h gid=%b tmo=%b stray=%b",
                    rd_en, rd_addr, rd_len, grant_id, arb_timeout, stray_beat),
          "all zero");

    foreach (tbl[i]) begin
      vec_t v;
      bit ok;
      v = tbl[i];
      @(negedge clk);
      rst       = v.rst;
      req_valid = v.rv;
      rd_busy   = v.busy;
      rd_dv     = v.dv;
      req_len   = {v.l1, v.l0};
      rd_data   = DW'(i);
      #1;
      ok = req_ready === v.rdy && rd_en === v.en &&
           resp_valid === v.rvl && resp_last === v.rl &&
           grant_id === v.gid && stray_beat === v.stray &&
           arb_timeout === v.tmo;
      if (v.en)
        ok = ok && rd_addr === (v.gid ? A1 : A0) &&
             rd_len === (v.gid ? v.l1 : v.l0);
      if (v.rvl != 2'b00)
        ok = ok && resp_data === DW'(i);
      check($sformatf("vec%0d", i), ok,
            $sformatf("rdy=%b en=%b rv=%b rl=%b gid=%b stray=%b tmo=%b addr=%h len=%0d",
                      req_ready, rd_en, resp_valid, resp_last, grant_id,
                      stray_beat, arb_timeout, rd_addr, rd_len),
            $sformatf("rdy=%b en=%b rv=%b rl=%b gid=%b stray=%b tmo=%b",
                      v.rdy, v.en, v.rvl, v.rl, v.gid, v.stray, v.tmo));
    end

    // Test 4: len 255 burst from req0 (first winner after reset)
    rst = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    req_len   = {8'd3, 8'd255};
    rd_dv     = 1'b0;
    #1;
    check("long_accept", req_ready === 2'b01,
          $sformatf("%b", req_ready), "01");
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("long_issue", rd_en === 1'b1 && rd_len === 8'd255 && rd_addr === A0,
          $sformatf("en=%b len=%0d addr=%h", rd_en, rd_len, rd_addr),
          "en=1 len=255 addr=1000");
    cnt     = 0;
    lastpos = -1;
    data_ok = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      rd_dv   = 1'b1;
      rd_data = DW'(k + 'h100);
      #1;
      if (resp_valid === 2'b01) cnt++;
      if (resp_last !== 2'b00) lastpos = (resp_last === 2'b01) ? k : -2;
      if (resp_data !== DW'(k + 'h100)) data_ok = 1'b0;
    end
    @(negedge clk);
    rd_dv = 1'b0;
    #1;
    check("long_beats", cnt == 256, $sformatf("%0d", cnt), "256");
    check("long_last", lastpos == 255, $sformatf("%0d", lastpos), "255");
    check("long_data", data_ok, "mismatch", "beat data");
    req_valid = 2'b01;
    #1;
    check("long_idle", req_ready === 2'b01 && resp_valid === 2'b00,
          $sformatf("rdy=%b rv=%b", req_ready, resp_valid), "rdy=01 rv=00");
    @(negedge clk);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
